sysbus_arbiter: RTL and testbench

Round-robin arbiter that shares the processor's single tri-state `sysbus` between up to `N` bus drivers: the sequencer, the switch input buffer, the display register loader and a spare master. It issues registered one-hot drive grants and inserts one dead cycle between owners so two tri-state drivers never overlap. An optional hold-timeout forces a stuck owner off the bus. It sits beside the sequencer in the CPU top level; each requester gates its bus driver with its grant bit.

---
 rtl/sysbus_pkg.sv | 35 +++
 rtl/sysbus_arbiter_rr_pick.sv | 27 ++
 rtl/sysbus_arbiter.sv | 138 +++++++++++++
 tb/tb_sysbus_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sysbus_pkg.sv
// Shared types and helpers for the system-bus arbiter: FSM state encoding,
// owner index width and the round-robin first-set search.
package sysbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_t;

  localparam int ARB_N  = 4;
  localparam int RR_MAX = 32;

  function automatic int owner_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int OWNER_W = owner_width(ARB_N);

  // Index of the first set bit at or above ptr, wrapping at n.
  function automatic int rr_first(input logic [RR_MAX-1:0] req, input int ptr, input int n);
    logic [RR_MAX-1:0] rot;
    int                first;
    rot = '0;
    for (int i = 0; i < RR_MAX; i++) begin
      if (i < n) rot[i] = req[5'((ptr + i) % n)];
    end
    first = 0;
    for (int i = RR_MAX - 1; i >= 0; i--) begin
      if (rot[i]) first = i;
    end
    return (ptr + first) % n;
  endfunction

endpackage

// File: rtl/sysbus_arbiter_rr_pick.sv
// Combinational round-robin picker; a locked previous owner that asks
// again wins outright.
module rr_pick
  import sysbus_pkg::*;
#(
  parameter int N  = ARB_N,
  parameter int OW = owner_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [OW-1:0] ptr,
  input  logic          lock_hit,
  input  logic [OW-1:0] last_owner,
  output logic [OW-1:0] winner,
  output logic          any
);

  logic [RR_MAX-1:0] req_ext;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    any            = |req;
    if (lock_hit) winner = last_owner;
    else          winner = OW'(rr_first(req_ext, int'(ptr), N));
  end

endmodule

// File: rtl/sysbus_arbiter.sv
// Round-robin sysbus arbiter with a one-cycle dead slot between owners.
// Define SYSBUS_ARB_TIMEOUT_EN to build the forced-release hold timeout.
module sysbus_arbiter
  import sysbus_pkg::*;
#(
  parameter  int N        = ARB_N,
  parameter  int MAX_HOLD = 8,
  localparam int OW       = owner_width(N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  lock,
  output logic [N-1:0]  grant,
  output logic [OW-1:0] owner,
  output logic          owner_valid,
  output logic          turnaround,
  output logic          timeout_err
);

  arb_state_t    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [OW-1:0] last_q, last_d;
  logic [OW-1:0] winner;
  logic          turn_q, turn_d;
  logic          lock_rel_q, lock_rel_d;
  logic          lock_hit, any, force_rel;

  if (N < 2 || N > RR_MAX) begin : g_bad_n
    $error("sysbus_arbiter: N out of range");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("sysbus_arbiter: MAX_HOLD must be in 1..255");
  end

  assign lock_hit = lock_rel_q & req[last_q];

  rr_pick #(.N(N), .OW(OW)) u_pick (
    .req        (req),
    .ptr        (ptr_q),
    .lock_hit   (lock_hit),
    .last_owner (last_q),
    .winner     (winner),
    .any        (any)
  );

`ifdef SYSBUS_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  logic [7:0] hold_q, hold_d, hold_inc;
  logic       terr_q;

  // hold_inc is the owner-cycle count including the current cycle
  always_comb begin
    hold_inc  = (hold_q == HOLD_LIM) ? hold_q : hold_q + 8'd1;
    hold_d    = (state_q == OWN) ? hold_inc : 8'd0;
    force_rel = (state_q == OWN) && req[owner_q] && !lock[owner_q] &&
                (hold_inc == HOLD_LIM) && (|(req & ~grant_q));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_q <= 8'd0;
      terr_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      terr_q <= force_rel;
    end
  end

  assign timeout_err = terr_q;
`else
  assign force_rel   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    last_d     = last_q;
    lock_rel_d = lock_rel_q;
    turn_d     = 1'b0;
    case (state_q)
      OWN: begin
        if (!req[owner_q] || force_rel) begin
          state_d    = TURN;
          grant_d    = '0;
          owner_d    = '0;
          turn_d     = 1'b1;
          last_d     = owner_q;
          lock_rel_d = !req[owner_q] && lock[owner_q];
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        owner_d = '0;
        if (any) begin
          state_d         = OWN;
          grant_d[winner] = 1'b1;
          owner_d         = winner;
          lock_rel_d      = 1'b0;
          if (!lock_hit) ptr_d = (int'(winner) == N - 1) ? '0 : OW'(winner + 1'b1);
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      last_q     <= '0;
      lock_rel_q <= 1'b0;
      turn_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      last_q     <= last_d;
      lock_rel_q <= lock_rel_d;
      turn_q     <= turn_d;
    end
  end

  assign grant       = grant_q;
  assign owner       = owner_q;
  assign owner_valid = |grant_q;
  assign turnaround  = turn_q;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Self-checking bench for sysbus_arbiter: directed scenarios with literal
// expectations plus a randomized run against a behavioural model.
module tb_sysbus_arbiter;

  localparam int N    = 4;
  localparam int MAXH = 8;
`ifdef SYSBUS_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] req, lock, grant;
  logic [1:0]   owner;
  logic         owner_valid, turnaround, timeout_err;

  int checks = 0;
  int errors = 0;

  sysbus_arbiter #(.N(N), .MAX_HOLD(MAXH)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .lock        (lock),
    .grant       (grant),
    .owner       (owner),
    .owner_valid (owner_valid),
    .turnaround  (turnaround),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got 'h%0h, expected 'h%0h", name, $time, act, exp);
    end
  endtask

  function automatic bit bitof(input logic [N-1:0] v, input int i);
    logic [N-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  // Behavioural model: owner index (-1 = bus free), pointer, hold count.
  int m_owner = -1, m_ptr = 0, m_last = 0, m_hold = 0;
  bit m_turn = 0, m_terr = 0, m_lockrel = 0;

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      m_owner = -1; m_ptr = 0; m_last = 0; m_hold = 0;
      m_turn = 0; m_terr = 0; m_lockrel = 0;
    end else if (m_owner >= 0) begin
      logic [N-1:0] others;
      others = req & ~(N'(1) << m_owner);
      m_turn = 0; m_terr = 0;
      m_hold = (m_hold + 1 > MAXH) ? MAXH : m_hold + 1;
      if (!bitof(req, m_owner)) begin
        m_last = m_owner; m_lockrel = bitof(lock, m_owner); m_owner = -1; m_turn = 1;
      end else if (TMO && m_hold == MAXH && !bitof(lock, m_owner) && others != 0) begin
        m_last = m_owner; m_lockrel = 0; m_owner = -1; m_turn = 1; m_terr = 1;
      end
    end else begin
      m_turn = 0; m_terr = 0;
      if (req != 0) begin
        int w;
        w = -1;
        if (m_lockrel && bitof(req, m_last)) w = m_last;
        else begin
          for (int k = 0; k < N; k++)
            if (w < 0 && bitof(req, (m_ptr + k) % N)) w = (m_ptr + k) % N;
          m_ptr = (w + 1) % N;
        end
        m_owner = w; m_hold = 0; m_lockrel = 0;
      end
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  logic [N-1:0] prev_grant = '0;
  initial forever begin
    logic [N-1:0] eg;
    @(negedge clock);
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    check("model_grant", int'(grant), int'(eg));
    check("model_owner", int'(owner), (m_owner >= 0) ? m_owner : 0);
    check("model_valid", int'(owner_valid), (m_owner >= 0) ? 1 : 0);
    check("model_turn", int'(turnaround), int'(m_turn));
    check("model_terr", int'(timeout_err), int'(m_terr));
    check("onehot0", int'($onehot0(grant)), 1);
    if (prev_grant != '0 && grant != '0) check("no_direct_switch", int'(grant), int'(prev_grant));
    prev_grant = grant;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; lock = '0;
    step(); step();
    check("rst_grant", int'(grant), 0);
    check("rst_owner", int'(owner), 0);
    check("rst_valid", int'(owner_valid), 0);
    check("rst_turn", int'(turnaround), 0);
    check("rst_terr", int'(timeout_err), 0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; req = '0; lock = '0;
    #1;
    do_reset();

    // grant from idle, then release into competing requesters
    req = 'b0100; step();
    check("t1_grant", int'(grant), 'b0100);
    check("t1_owner", int'(owner), 2);
    check("t1_valid", int'(owner_valid), 1);
    req = 'b1011; step();
    check("t2_turn_grant", int'(grant), 0);
    check("t2_turn", int'(turnaround), 1);
    step();
    check("t2_grant3", int'(grant), 'b1000);
    check("t2_owner3", int'(owner), 3);
    check("t2_turn_lo", int'(turnaround), 0);
    req = 'b0011; step();
    check("t2_turn2", int'(turnaround), 1);
    step();
    check("t2_grant0", int'(grant), 'b0001);
    req = '0; step(); step();
    check("t2_idle_grant", int'(grant), 0);
    check("t2_idle_turn", int'(turnaround), 0);

    // hold timeout with a competitor
    do_reset();
    req = 'b0011;
    for (int k = 0; k < 8; k++) begin
      step();
      check("t3_hold_grant", int'(grant), 'b0001);
      check("t3_hold_terr", int'(timeout_err), 0);
    end
    step();
`ifdef SYSBUS_ARB_TIMEOUT_EN
    check("t3_forced_grant", int'(grant), 0);
    check("t3_forced_turn", int'(turnaround), 1);
    check("t3_forced_terr", int'(timeout_err), 1);
    step();
    check("t3_next_grant", int'(grant), 'b0010);
    check("t3_terr_pulse", int'(timeout_err), 0);
`else
    check("t3_kept_grant", int'(grant), 'b0001);
    check("t3_no_terr", int'(timeout_err), 0);
    step();
    check("t3_still_kept", int'(grant), 'b0001);
`endif

    // locked owner keeps the bus
    do_reset();
    lock = 'b0001; req = 'b0011;
    for (int k = 0; k < 50; k++) begin
      step();
      check("t4_lock_grant", int'(grant), 'b0001);
    end

    // locked release: same owner wins again, pointer left alone
    do_reset();
    req = 'b0010; step();
    check("t5_grant1", int'(grant), 'b0010);
    lock = 'b0010; req = 'b1100; step();
    check("t5_turn", int'(turnaround), 1);
    req = 'b1110; step();
    check("t5_regrant1", int'(grant), 'b0010);
    check("t5_owner1", int'(owner), 1);
    lock = '0; req = 'b1101; step();
    check("t5_turn2", int'(turnaround), 1);
    step();
    check("t5_grant2", int'(grant), 'b0100);

    // asynchronous reset mid-ownership
    do_reset();
    req = 'b0100; step();
    check("t6_grant2", int'(grant), 'b0100);
    @(negedge clock); #2;
    reset = 1'b1;
    #1;
    check("t6_async_grant", int'(grant), 0);
    check("t6_async_valid", int'(owner_valid), 0);
    req = 'b1000; step(); step();
    reset = 1'b0;
    step();
    check("t6_grant3", int'(grant), 'b1000);
    check("t6_owner3", int'(owner), 3);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) req = req ^ (N'(1) << b);
      lock = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 299) == 0) begin
        #2; reset = 1'b1;
        step();
        reset = 1'b0;
      end
    end

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
